hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Pipeline hazard tracker that sits directly downstream of the decode-stage control unit.
- Consumes per-instruction Tuse/Tnew codes and register addresses, and carries write-back records through the E, M and W stages.
- Produces the D-stage stall, bubble insertion, and forwarding-mux selects for the D, E and M stages.
- Owns the only state used for hazard resolution; the datapath pipeline registers follow its stall output.

Parameters:
- REG_AW, 5, register address width.
- T_W, 5, width of the Tuse/Tnew code fields.
- TUSE_NONE, 16, Tuse code meaning "operand not read".

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_rs  in  REG_AW  D-stage rs address.
- d_rt  in  REG_AW  D-stage rt address.
- d_rs_tuse  in  T_W  rs Tuse code: 0 or 1; TUSE_NONE means unused.
- d_rt_tuse  in  T_W  rt Tuse code: 0, 1 or 2; TUSE_NONE means unused.
- d_tnew  in  T_W  Tnew at E entry: 0, 1 or 2; any value >=3 means no write.
- d_regw_en  in  1  D instruction writes the register file.
- d_dst  in  REG_AW  resolved destination register (rt, rd or 31).
- stall  out  1  hold PC and the F/D register, bubble the D/E register.
- fwd_rs_d  out  2  D rs source: 0 regfile, 1 E, 2 M, 3 W.
- fwd_rt_d  out  2  D rt source: same encoding as fwd_rs_d.
- fwd_rs_e  out  2  E rs source: 0 pipeline register, 2 M, 3 W.
- fwd_rt_e  out  2  E rt source: same encoding as fwd_rs_e.
- fwd_rt_m  out  1  M store data: 0 pipeline register, 1 W.
- stall_cnt  out  32  stall-cycle count; present only with HAZ_STALL_CNT_EN.

Behaviour:
- Records:
  - Stage records exist for E, M and W.
  - Each record holds {valid, dst, tnew}.
  - The E record additionally holds rs, rt, rs_tuse and rt_tuse; the M record holds rt.
- Record creation:
  - A D instruction creates a valid record only if d_regw_en=1, d_tnew<3 and d_dst!=0.
  - Otherwise the record has valid=0, but its rs/rt fields are still carried for E/M forwarding.
- Reset:
  - reset low clears every record asynchronously (valid=0, fields 0).
  - All outputs are combinational from the records, so they read 0 during and after reset.
- Advance (every rising edge, never frozen):
  - W<=M with tnew forced to 0.
  - M<=E with tnew=max(E.tnew-1,0).
  - E<=D record if stall=0, else E<=bubble (all-zero).
  - A stall therefore inserts exactly one bubble per stalled cycle; D is held by the datapath.
- Stall (combinational):
  - For each operand X in {rs, rt} with tuse!=TUSE_NONE and addr!=0: stall if (E.valid & E.dst==addr & E.tnew>tuse) or (M.valid & M.dst==addr & M.tnew>tuse).
  - stall = OR over both operands.
  - A W match never stalls.
- D forwarding:
  - Priority E > M > W; first matching valid record with tnew==0 is selected.
  - addr==0 always yields 0.
  - When stall=1 the fwd_*_d values are don't-care but must still be deterministic.
- E forwarding:
  - Compare E.rs/E.rt against M (tnew==0) first, then W.
  - A bubble in E has rs=rt=0, giving select 0.
- M forwarding:
  - fwd_rt_m=1 iff W.valid & W.dst==M.rt & M.rt!=0.
- Latency: stall and fwd outputs are same-cycle combinational. A load-use pair stalls exactly 1 cycle (tnew=2, tuse=1), or 2 cycles for a branch consumer (tuse=0).
- Simultaneous matches: the nearest stage wins. Two records with the same dst resolve to the younger one.
- Mid-stall reset clears all records; stall deasserts immediately.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- When defined:
  - 32-bit stall_cnt register increments on each rising edge where stall=1.
  - Wraps at 2^32-1 to 0.
  - Cleared by reset.
- When undefined: the port and register are absent; there is no other change.

Decomposition:
- Shared package / macros file holds:
  - T_NONE_CODE (16).
  - Forward-select encodings FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - The stage-record struct/field widths.
- One natural sub-module: hazard_fwd_pick. It is combinational and takes an address plus three records, returning the 2-bit select. It is instantiated for D rs/rt and E rs/rt.

Test Plan:
- lw $1 (tnew=2) followed by add using $1 (rs tuse=1): stall=1 for 1 cycle, then fwd_rs_e=3 (W) at E.
- ori $2 (tnew=1) followed by beq on $2 (tuse=0): stall=1 for 1 cycle, then fwd_rs_d=2 (M).
- jal (tnew=0, dst=31) followed by jr $31: no stall, fwd_rs_d=1 (E).
- Writes to $0 with d_regw_en=1, then a consumer of $0: stall=0 and all selects 0.
- add $3 followed by add $3 followed by sw using $3: fwd_rt_e selects M (the younger writer), not W; a lw->sw data pair yields fwd_rt_m=1.
- Assert reset mid-stall with a lw record in E: stall drops to 0 at once, all selects read 0, and stall_cnt=0 (HAZ_STALL_CNT_EN build).

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the pipeline hazard scoreboard:
//   - default field widths and the "operand not read" Tuse code
//   - forwarding-select encodings used by every fwd_* output
//   - stage-record structs for the E, M and W stages
//   - tnew_dec: saturating one-stage decrement of a Tnew code
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int REC_AW      = 5;   // register address width
    localparam int REC_TW      = 5;   // Tuse/Tnew code width
    localparam int T_NONE_CODE = 16;  // Tuse code: operand not read

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Common part of every stage record: who writes what, and how many
    // stages remain before the result exists.
    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] dst;
        logic [REC_TW-1:0] tnew;
    } stage_rec_t;

    // E record also carries the operand addresses for E-stage forwarding.
    typedef struct packed {
        stage_rec_t        base;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
        logic [REC_TW-1:0] rs_tuse;
        logic [REC_TW-1:0] rt_tuse;
    } e_rec_t;

    // M record keeps rt for store-data forwarding from W.
    typedef struct packed {
        stage_rec_t        base;
        logic [REC_AW-1:0] rt;
    } m_rec_t;

    function automatic logic [REC_TW-1:0] tnew_dec(input logic [REC_TW-1:0] t);
        return (t == '0) ? '0 : t - REC_TW'(1);
    endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// -----------------------------------------------------------------------------
// hazard_fwd_pick
// Combinational forwarding-source selector for one operand.
//   addr  : operand register address (0 never forwards)
//   e_rec : E-stage record (tie to '0 when E is not a candidate source)
//   m_rec : M-stage record
//   w_rec : W-stage record
//   sel   : FWD_RF / FWD_E / FWD_M / FWD_W
// The nearest matching valid record owns the register. If that record's
// result is not ready yet (tnew!=0), older records hold stale data, so the
// select falls back to FWD_RF rather than reaching past it.
// -----------------------------------------------------------------------------
module hazard_fwd_pick
    import hazard_scoreboard_pkg::*;
(
    input  logic [REC_AW-1:0] addr,
    input  stage_rec_t        e_rec,
    input  stage_rec_t        m_rec,
    input  stage_rec_t        w_rec,
    output logic [1:0]        sel
);

    logic e_hit, m_hit, w_hit;

    always_comb begin
        e_hit = e_rec.valid && (e_rec.dst == addr);
        m_hit = m_rec.valid && (m_rec.dst == addr);
        w_hit = w_rec.valid && (w_rec.dst == addr);
        sel   = FWD_RF;
        if (addr != '0) begin
            if (e_hit) begin
                sel = (e_rec.tnew == '0) ? FWD_E : FWD_RF;
            end else if (m_hit) begin
                sel = (m_rec.tnew == '0) ? FWD_M : FWD_RF;
            end else if (w_hit) begin
                sel = (w_rec.tnew == '0) ? FWD_W : FWD_RF;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Pipeline hazard tracker downstream of the decode-stage control unit. Keeps
// write-back records for E, M and W and derives the D-stage stall and the
// forwarding selects for the D, E and M stages.
//
// Ports:
//   clk, reset               clock (rising edge), async active-low reset
//   d_rs, d_rt               D-stage operand addresses
//   d_rs_tuse, d_rt_tuse     operand Tuse codes (TUSE_NONE = not read)
//   d_tnew                   Tnew at E entry (>=3 means no write)
//   d_regw_en, d_dst         register-file write enable and destination
//   stall                    hold PC and F/D, bubble D/E
//   fwd_rs_d, fwd_rt_d       D operand source (RF/E/M/W)
//   fwd_rs_e, fwd_rt_e       E operand source (pipe reg/M/W)
//   fwd_rt_m                 M store-data source (pipe reg/W)
//   stall_cnt                stall-cycle counter, only when the
//                            HAZ_STALL_CNT_EN macro is defined
//
// Records advance on every edge; a stall only replaces the incoming E record
// with a bubble. All outputs are combinational from the records and D inputs.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW    = REC_AW,
    parameter int T_W       = REC_TW,
    parameter int TUSE_NONE = T_NONE_CODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [T_W-1:0]    d_rs_tuse,
    input  logic [T_W-1:0]    d_rt_tuse,
    input  logic [T_W-1:0]    d_tnew,
    input  logic              d_regw_en,
    input  logic [REG_AW-1:0] d_dst,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [T_W-1:0] TUSE_NONE_C = T_W'(TUSE_NONE);
    localparam logic [T_W-1:0] TNEW_LIMIT  = T_W'(3);

    e_rec_t     e_q, e_n, d_rec;
    m_rec_t     m_q, m_n;
    stage_rec_t w_q, w_n;
    logic [REC_AW-1:0] e_rs_used, e_rt_used;

    // An operand must wait while a pending writer's result arrives later than
    // the operand is consumed. W results are always ready, so W never stalls.
    function automatic logic op_stall(input logic [REC_AW-1:0] addr,
                                      input logic [REC_TW-1:0] tuse,
                                      input e_rec_t            e,
                                      input m_rec_t            m);
        logic e_late, m_late;
        e_late = e.base.valid && (e.base.dst == addr) && (e.base.tnew > tuse);
        m_late = m.base.valid && (m.base.dst == addr) && (m.base.tnew > tuse);
        return (tuse != TUSE_NONE_C) && (addr != '0) && (e_late || m_late);
    endfunction

    // Incoming record: operand fields are always carried so E/M forwarding
    // still sees them even when the instruction does not write.
    always_comb begin
        d_rec            = '0;
        d_rec.base.valid = d_regw_en && (d_tnew < TNEW_LIMIT) && (d_dst != '0);
        d_rec.base.dst   = d_dst;
        d_rec.base.tnew  = d_tnew;
        d_rec.rs         = d_rs;
        d_rec.rt         = d_rt;
        d_rec.rs_tuse    = d_rs_tuse;
        d_rec.rt_tuse    = d_rt_tuse;
    end

    always_comb begin
        stall = op_stall(d_rs, d_rs_tuse, e_q, m_q) ||
                op_stall(d_rt, d_rt_tuse, e_q, m_q);
    end

    // Next-record computation for the always-advancing pipeline.
    always_comb begin
        e_n            = stall ? '0 : d_rec;
        m_n            = '0;
        m_n.base.valid = e_q.base.valid;
        m_n.base.dst   = e_q.base.dst;
        m_n.base.tnew  = tnew_dec(e_q.base.tnew);
        m_n.rt         = e_q.rt;
        w_n            = '0;
        w_n.valid      = m_q.base.valid;
        w_n.dst        = m_q.base.dst;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_n;
            m_q <= m_n;
            w_q <= w_n;
        end
    end

    // An operand the E instruction does not read never forwards.
    always_comb begin
        e_rs_used = (e_q.rs_tuse != TUSE_NONE_C) ? e_q.rs : '0;
        e_rt_used = (e_q.rt_tuse != TUSE_NONE_C) ? e_q.rt : '0;
    end

    hazard_fwd_pick u_pick_rs_d (
        .addr  (d_rs),
        .e_rec (e_q.base),
        .m_rec (m_q.base),
        .w_rec (w_q),
        .sel   (fwd_rs_d)
    );

    hazard_fwd_pick u_pick_rt_d (
        .addr  (d_rt),
        .e_rec (e_q.base),
        .m_rec (m_q.base),
        .w_rec (w_q),
        .sel   (fwd_rt_d)
    );

    // E-stage selects only look downstream, so the E slot is tied off.
    hazard_fwd_pick u_pick_rs_e (
        .addr  (e_rs_used),
        .e_rec ('0),
        .m_rec (m_q.base),
        .w_rec (w_q),
        .sel   (fwd_rs_e)
    );

    hazard_fwd_pick u_pick_rt_e (
        .addr  (e_rt_used),
        .e_rec ('0),
        .m_rec (m_q.base),
        .w_rec (w_q),
        .sel   (fwd_rt_e)
    );

    always_comb begin
        fwd_rt_m = w_q.valid && (w_q.dst == m_q.rt) && (m_q.rt != '0);
    end

`ifdef HAZ_STALL_CNT_EN
    // Free-running count of stalled edges; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed instruction sequences for hazard_scoreboard. Each D-stage cycle
// pushes its hand-derived output vector
// {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} onto exp_q; the
// vector is popped and compared at the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam logic [4:0] NONE = 5'd16;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rs_tuse;
        logic [4:0] rt_tuse;
        logic [4:0] tnew;
        logic       regw;
        logic [4:0] dst;
    } instr_t;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_tnew, d_dst;
    logic       d_regw_en;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp;
    int         n_bad;
    int         exp_stall_cnt;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_tnew    (d_tnew),
        .d_regw_en (d_regw_en),
        .d_dst     (d_dst),
        .stall     (stall),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .fwd_rt_m  (fwd_rt_m)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rs_tuse, input logic [4:0] rt_tuse,
                                  input logic [4:0] tnew, input logic regw,
                                  input logic [4:0] dst);
        return '{rs: rs, rt: rt, rs_tuse: rs_tuse, rt_tuse: rt_tuse,
                 tnew: tnew, regw: regw, dst: dst};
    endfunction

    function automatic logic [9:0] ev(input logic st, input logic [1:0] rsd,
                                      input logic [1:0] rtd, input logic [1:0] rse,
                                      input logic [1:0] rte, input logic rtm);
        return {st, rsd, rtd, rse, rte, rtm};
    endfunction

    task automatic drive(input instr_t i);
        d_rs      = i.rs;
        d_rt      = i.rt;
        d_rs_tuse = i.rs_tuse;
        d_rt_tuse = i.rt_tuse;
        d_tnew    = i.tnew;
        d_regw_en = i.regw;
        d_dst     = i.dst;
    endtask

    task automatic push_exp(input logic [9:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        logic [9:0] e;
        string      t;
        logic [9:0] obs;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
        check(t, {22'd0, obs}, {22'd0, e});
    endtask

    // One pipeline cycle: instruction sits in D after a rising edge, outputs
    // are checked at the falling edge, the next rising edge advances.
    task automatic step(input instr_t i, input logic [9:0] e, input string tag);
        @(posedge clk);
        #1;
        drive(i);
        push_exp(e, tag);
        @(negedge clk);
        compare_out();
`ifdef HAZ_STALL_CNT_EN
        check({tag, ".cnt"}, stall_cnt, exp_stall_cnt);
`endif
        if (e[9]) exp_stall_cnt++;
    endtask

    task automatic flush();
        repeat (3) begin
            @(posedge clk);
            #1;
            drive(mk(5'd0, 5'd0, NONE, NONE, 5'd3, 1'b0, 5'd0));
        end
    endtask

    // ---------------- stimulus ----------------
    instr_t lw1, add1, ori2, beq2, jal31, jr31, wr0, use0;
    instr_t a3a, a3b, sw3, lw4, sw4, lw7, beq7, nop_i;

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        exp_stall_cnt = 0;

        nop_i = mk(5'd0,  5'd0,  NONE, NONE, 5'd3, 1'b0, 5'd0);
        lw1   = mk(5'd5,  5'd1,  5'd1, NONE, 5'd2, 1'b1, 5'd1);
        add1  = mk(5'd1,  5'd6,  5'd1, 5'd1, 5'd1, 1'b1, 5'd4);
        ori2  = mk(5'd7,  5'd2,  5'd1, NONE, 5'd1, 1'b1, 5'd2);
        beq2  = mk(5'd2,  5'd8,  5'd0, 5'd0, 5'd3, 1'b0, 5'd0);
        jal31 = mk(5'd0,  5'd0,  NONE, NONE, 5'd0, 1'b1, 5'd31);
        jr31  = mk(5'd31, 5'd0,  5'd0, NONE, 5'd3, 1'b0, 5'd0);
        wr0   = mk(5'd9,  5'd0,  5'd1, NONE, 5'd1, 1'b1, 5'd0);
        use0  = mk(5'd0,  5'd0,  5'd1, 5'd1, 5'd1, 1'b1, 5'd5);
        a3a   = mk(5'd10, 5'd11, 5'd1, 5'd1, 5'd1, 1'b1, 5'd3);
        a3b   = mk(5'd12, 5'd13, 5'd1, 5'd1, 5'd1, 1'b1, 5'd3);
        sw3   = mk(5'd14, 5'd3,  5'd1, 5'd2, 5'd3, 1'b0, 5'd0);
        lw4   = mk(5'd5,  5'd4,  5'd1, NONE, 5'd2, 1'b1, 5'd4);
        sw4   = mk(5'd6,  5'd4,  5'd1, 5'd2, 5'd3, 1'b0, 5'd0);
        lw7   = mk(5'd5,  5'd7,  5'd1, NONE, 5'd2, 1'b1, 5'd7);
        beq7  = mk(5'd7,  5'd0,  5'd0, 5'd0, 5'd3, 1'b0, 5'd0);

        // Reset state: a consumer in D sees nothing while reset is held.
        reset = 1'b0;
        drive(add1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_exp(ev(0, 0, 0, 0, 0, 0), "reset.outputs");
        compare_out();
`ifdef HAZ_STALL_CNT_EN
        check("reset.cnt", stall_cnt, 32'd0);
`endif
        drive(nop_i);
        reset = 1'b1;

        // lw -> add: one stall, then W forwards to E.
        flush();
        step(lw1,   ev(0, 0, 0, 0, 0, 0), "lw_use.lw");
        step(add1,  ev(1, 0, 0, 0, 0, 0), "lw_use.stall");
        step(add1,  ev(0, 0, 0, 0, 0, 0), "lw_use.release");
        step(nop_i, ev(0, 0, 0, 3, 0, 0), "lw_use.fwd_e_w");

        // ori -> beq: one stall, then M forwards to D.
        flush();
        step(ori2,  ev(0, 0, 0, 0, 0, 0), "ori_beq.ori");
        step(beq2,  ev(1, 0, 0, 0, 0, 0), "ori_beq.stall");
        step(beq2,  ev(0, 2, 0, 0, 0, 0), "ori_beq.fwd_d_m");

        // jal -> jr: no stall, E forwards to D.
        flush();
        step(jal31, ev(0, 0, 0, 0, 0, 0), "jal_jr.jal");
        step(jr31,  ev(0, 1, 0, 0, 0, 0), "jal_jr.fwd_d_e");

        // Writes to $0 never create hazards or forwarding.
        flush();
        step(wr0,   ev(0, 0, 0, 0, 0, 0), "zero.write");
        step(use0,  ev(0, 0, 0, 0, 0, 0), "zero.use");
        step(nop_i, ev(0, 0, 0, 0, 0, 0), "zero.e_stage");

        // Two writers of $3: the younger (M) wins over W at E.
        flush();
        step(a3a,   ev(0, 0, 0, 0, 0, 0), "dup.first");
        step(a3b,   ev(0, 0, 0, 0, 0, 0), "dup.second");
        step(sw3,   ev(0, 0, 0, 0, 0, 0), "dup.sw_no_stall");
        step(nop_i, ev(0, 0, 0, 0, 2, 0), "dup.fwd_e_m");

        // lw -> sw data: no stall, store data forwarded W -> M.
        flush();
        step(lw4,   ev(0, 0, 0, 0, 0, 0), "lw_sw.lw");
        step(sw4,   ev(0, 0, 0, 0, 0, 0), "lw_sw.sw");
        step(nop_i, ev(0, 0, 0, 0, 0, 0), "lw_sw.e_not_ready");
        step(nop_i, ev(0, 0, 0, 0, 0, 1), "lw_sw.fwd_m_w");

        // lw -> beq: two stall cycles, then W forwards to D.
        flush();
        step(lw7,   ev(0, 0, 0, 0, 0, 0), "lw_br.lw");
        step(beq7,  ev(1, 0, 0, 0, 0, 0), "lw_br.stall1");
        step(beq7,  ev(1, 0, 0, 0, 0, 0), "lw_br.stall2");
        step(beq7,  ev(0, 3, 0, 0, 0, 0), "lw_br.fwd_d_w");

        // Reset asserted in the middle of a stall.
        flush();
        step(lw1,   ev(0, 0, 0, 0, 0, 0), "mid_rst.lw");
        step(add1,  ev(1, 0, 0, 0, 0, 0), "mid_rst.stall");
        #2;
        reset = 1'b0;
        #1;
        push_exp(ev(0, 0, 0, 0, 0, 0), "mid_rst.cleared");
        compare_out();
        exp_stall_cnt = 0;
`ifdef HAZ_STALL_CNT_EN
        check("mid_rst.cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step(add1,  ev(0, 0, 0, 0, 0, 0), "mid_rst.after");

        check("sb.drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
